cpu_register_write_arbiter: RTL and testbench

Shares the single write port of the CPU register file among several write requesters (ALU writeback, load unit, debug/host loader, etc.) using round-robin arbitration with a valid/ready handshake per requester. Grants at most one write per cycle and drives the register file's write-enable, write-address and write-data inputs from a one-stage output register. Sits directly between the writeback sources and `cpu_register_file`.

---
 rtl/cpu_regfile_pkg.sv | 18 +
 rtl/round_robin_arbiter.sv | 31 +++
 rtl/cpu_register_write_arbiter.sv | 105 ++++++++++
 tb/tb_cpu_register_write_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_regfile_pkg.sv
// Shared register-file types and default widths for cpu_register_file and its write-side users.
package cpu_regfile_pkg;

  localparam int BUS_WIDTH          = 8;
  localparam int DEFAULT_DATA_WIDTH = BUS_WIDTH;
  localparam int DEFAULT_REG_COUNT  = 256;
  localparam int REG_ADDR_WIDTH     = $clog2(DEFAULT_REG_COUNT);

  typedef logic [REG_ADDR_WIDTH-1:0]            reg_addr_t;
  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    reg_data_t data;
  } regfile_write_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: search starts one past ptr_in and wraps; the pointer register lives in the caller.
module round_robin_arbiter #(
  parameter int N  = 4,
  localparam int GW = $clog2(N)
) (
  input  logic [N-1:0]  req_in,
  input  logic [GW-1:0] ptr_in,
  input  logic          enable_in,
  output logic [N-1:0]  grant_out,
  output logic [GW-1:0] grant_idx_out
);

  logic found;
  int   idx;

  always_comb begin
    grant_out     = '0;
    grant_idx_out = ptr_in;
    found         = 1'b0;
    idx           = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_in) + k) % N;
      if (!found && req_in[idx]) begin
        found              = 1'b1;
        grant_out[idx]     = enable_in;
        grant_idx_out      = idx[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/cpu_register_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with a one-stage registered write output.
// Optional per-requester grant counters are enabled with the WRITE_ARB_STATS_EN macro.
module cpu_register_write_arbiter
  import cpu_regfile_pkg::*;
#(
  parameter int NUM_REQUESTERS      = 4,
  parameter int NUMBER_OF_REGISTERS = DEFAULT_REG_COUNT,
  parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
  localparam int A  = $clog2(NUMBER_OF_REGISTERS),
  localparam int GW = $clog2(NUM_REQUESTERS)
) (
  input  logic                                      clock_in,
  input  logic                                      reset_in,
  input  logic                                      stall_in,
  input  logic [NUM_REQUESTERS-1:0]                 req_valid_in,
  input  logic [NUM_REQUESTERS-1:0][A-1:0]          req_address_in,
  input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQUESTERS-1:0]                 req_ready_out,
  output logic                                      write_enable_out,
  output logic [A-1:0]                              write_register_address_out,
  output logic [DATA_WIDTH-1:0]                     write_data_out,
`ifdef WRITE_ARB_STATS_EN
  output logic [NUM_REQUESTERS-1:0][15:0]           grant_count_out,
`endif
  output logic [GW-1:0]                             last_grant_out
);

  typedef struct packed {
    logic                         we;
    logic [A-1:0]                 addr;
    logic signed [DATA_WIDTH-1:0] data;
  } wr_out_t;

  logic [GW-1:0]             ptr_q, ptr_d;
  wr_out_t                   out_q, out_d;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [GW-1:0]             grant_idx;
  logic                      arb_enable;
  logic                      handshake;
  logic [A-1:0]              sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;

  // Ready is gated by reset_in too, so nothing handshakes while reset is held.
  assign arb_enable = ~stall_in & reset_in;

  round_robin_arbiter #(.N(NUM_REQUESTERS)) u_rr (
    .req_in        (req_valid_in),
    .ptr_in        (ptr_q),
    .enable_in     (arb_enable),
    .grant_out     (grant),
    .grant_idx_out (grant_idx)
  );

  assign req_ready_out = grant;
  assign handshake     = |grant;
  assign sel_addr      = req_address_in[grant_idx];
  assign sel_data      = req_data_in[grant_idx];

  always_comb begin
    ptr_d    = ptr_q;
    out_d    = out_q;
    out_d.we = 1'b0;
    if (handshake) begin
      ptr_d      = grant_idx;
      // Register 0 is hardwired zero: the handshake completes but the write is dropped.
      out_d.we   = (sel_addr != '0);
      out_d.addr = sel_addr;
      out_d.data = sel_data;
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      ptr_q <= GW'(NUM_REQUESTERS - 1);
      out_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      out_q <= out_d;
    end
  end

  assign write_enable_out           = out_q.we;
  assign write_register_address_out = out_q.addr;
  assign write_data_out             = out_q.data;
  assign last_grant_out             = ptr_q;

`ifdef WRITE_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_stats
    logic [15:0] count_q, count_d;

    always_comb begin
      count_d = count_q;
      if (grant[gi] && count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) count_q <= '0;
      else           count_q <= count_d;
    end

    assign grant_count_out[gi] = count_q;
  end
`endif

endmodule

// File: tb/tb_cpu_register_write_arbiter.sv
// Directed bench for cpu_register_write_arbiter; stats checks run when WRITE_ARB_STATS_EN is defined.
module tb_cpu_register_write_arbiter;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            stall;
  logic [3:0]      valid;
  logic [3:0][7:0] addr;
  logic [3:0][7:0] data;
  logic [3:0]      ready;
  logic            we;
  logic [7:0]      wr_addr;
  logic [7:0]      wr_data;
  logic [1:0]      last_grant;
`ifdef WRITE_ARB_STATS_EN
  logic [3:0][15:0] grant_count;
`endif

  int total  = 0;
  int passed = 0;

  cpu_register_write_arbiter #(
    .NUM_REQUESTERS(4), .NUMBER_OF_REGISTERS(256), .DATA_WIDTH(8)
  ) dut (
    .clock_in                   (clk),
    .reset_in                   (reset_n),
    .stall_in                   (stall),
    .req_valid_in               (valid),
    .req_address_in             (addr),
    .req_data_in                (data),
    .req_ready_out              (ready),
    .write_enable_out           (we),
    .write_register_address_out (wr_addr),
    .write_data_out             (wr_data),
`ifdef WRITE_ARB_STATS_EN
    .grant_count_out            (grant_count),
`endif
    .last_grant_out             (last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed grant sequences and the write each grant produces.
  int         seq_alt [4] = '{0, 2, 0, 2};
  int         seq_all [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
  logic [7:0] exp_a;
  logic [7:0] exp_d;

  initial begin
    reset_n = 1'b0;
    stall   = 1'b0;
    valid   = '0;
    addr    = '0;
    data    = '0;
    #12;
    chk("reset_we", 64'(we), 64'd0);
    chk("reset_addr", 64'(wr_addr), 64'd0);
    chk("reset_data", 64'(wr_data), 64'd0);
    chk("reset_last_grant", 64'(last_grant), 64'd3);
    chk("reset_ready", 64'(ready), 64'd0);
    step();
    reset_n = 1'b1;
    #1;

    // Requesters 0 and 2 alternate.
    addr[0] = 8'd5; data[0] = 8'd17;
    addr[2] = 8'd9; data[2] = 8'hFD;
    valid   = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt_ready_%0d", i), 64'(ready), 64'(4'b0001 << seq_alt[i]));
      if (i > 0) begin
        exp_a = (seq_alt[i-1] == 0) ? 8'd5 : 8'd9;
        exp_d = (seq_alt[i-1] == 0) ? 8'd17 : 8'hFD;
        chk($sformatf("alt_we_%0d", i), 64'(we), 64'd1);
        chk($sformatf("alt_addr_%0d", i), 64'(wr_addr), 64'(exp_a));
        chk($sformatf("alt_data_%0d", i), 64'(wr_data), 64'(exp_d));
      end
      step();
    end
    valid = '0;
    #1;
    chk("alt_last_we", 64'(we), 64'd1);
    chk("alt_last_addr", 64'(wr_addr), 64'd9);
    chk("alt_last_data", 64'(wr_data), 64'hFD);
    chk("alt_last_grant", 64'(last_grant), 64'd2);
    chk("alt_idle_ready", 64'(ready), 64'd0);
    step();
    chk("alt_bubble_we", 64'(we), 64'd0);

    // All four valid: pointer sits at 2, so order begins at 3.
    for (int r = 0; r < 4; r++) begin
      addr[r] = 8'(r + 1);
      data[r] = 8'(10 + r);
    end
    valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("all_ready_%0d", i), 64'(ready), 64'(4'b0001 << seq_all[i]));
      if (i > 0) begin
        chk($sformatf("all_we_%0d", i), 64'(we), 64'd1);
        chk($sformatf("all_addr_%0d", i), 64'(wr_addr), 64'(seq_all[i-1] + 1));
        chk($sformatf("all_data_%0d", i), 64'(wr_data), 64'(seq_all[i-1] + 10));
      end
      step();
    end
    valid = '0;
    #1;
    chk("all_last_we", 64'(we), 64'd1);
    chk("all_last_addr", 64'(wr_addr), 64'd3);
    step();

    // Address-0 write from requester 1: accepted but dropped.
    addr[1] = 8'd0; data[1] = 8'h55;
    valid   = 4'b0010;
    #1;
    chk("zero_ready", 64'(ready), 64'b0010);
    step();
    valid = '0;
    #1;
    chk("zero_we", 64'(we), 64'd0);
    chk("zero_last_grant", 64'(last_grant), 64'd1);
    step();
    chk("zero_we_after", 64'(we), 64'd0);

    // Stall for three cycles with requester 3 waiting.
    addr[3] = 8'd7; data[3] = 8'd100;
    valid   = 4'b1000;
    stall   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_ready_%0d", i), 64'(ready), 64'd0);
      chk($sformatf("stall_we_%0d", i), 64'(we), 64'd0);
      step();
    end
    stall = 1'b0;
    #1;
    chk("unstall_ready", 64'(ready), 64'b1000);
    step();
    valid = '0;
    #1;
    chk("unstall_we", 64'(we), 64'd1);
    chk("unstall_addr", 64'(wr_addr), 64'd7);
    chk("unstall_data", 64'(wr_data), 64'd100);
    chk("unstall_last_grant", 64'(last_grant), 64'd3);
    step();

    // Reset mid-cycle after a handshake: pending write is lost.
    addr[2] = 8'd12; data[2] = 8'd33;
    addr[0] = 8'd20; data[0] = 8'd44;
    valid   = 4'b0100;
    #1;
    chk("rst_pre_ready", 64'(ready), 64'b0100);
    step();
    valid = 4'b0101;
    chk("rst_pre_we", 64'(we), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_last_grant", 64'(last_grant), 64'd3);
    step();
    reset_n = 1'b1;
    #1;
    chk("rst_release_ready", 64'(ready), 64'b0001);
    step();
    chk("rst_release_we", 64'(we), 64'd1);
    chk("rst_release_addr", 64'(wr_addr), 64'd20);
    valid = '0;
    step();

`ifdef WRITE_ARB_STATS_EN
    reset_n = 1'b0;
    #1;
    chk("stats_reset", 64'(grant_count), 64'd0);
    step();
    reset_n = 1'b1;
    addr[0] = 8'd1;
    valid   = 4'b0001;
    for (int i = 0; i < 70000; i++) step();
    valid = '0;
    #1;
    chk("stats_sat_0", 64'(grant_count[0]), 64'hFFFF);
    chk("stats_other_1", 64'(grant_count[1]), 64'd0);
    chk("stats_other_2", 64'(grant_count[2]), 64'd0);
    chk("stats_other_3", 64'(grant_count[3]), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
